noc_in_port: RTL and testbench
==============================

Name: noc_in_port

Overview:
- Receiving end of the router-to-router link. Collects one-hot requests from the five output-port sources that drive it (L, N, E, S, W).
- Arbitrates among them round-robin and returns a one-hot grant that the sources compare against their own request.
- Captures the granted 32-bit packet and pushes it into the local input FIFO, one write per handshake.
- One instance sits in front of each router input FIFO.

Parameters:
- DLEN, 32, packet width in bits.
- CNT_W, 16, width of the accepted-packet counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous reset, active-low.
- req  input  5  request bits, one per source; bit4 L, bit3 N, bit2 E, bit1 S, bit0 W.
- data_l  input  DLEN  packet from local source.
- data_n  input  DLEN  packet from north source.
- data_e  input  DLEN  packet from east source.
- data_s  input  DLEN  packet from south source.
- data_w  input  DLEN  packet from west source.
- grant  output  5  registered one-hot grant, same bit order as req; returned to the source's grant-compare input.
- fifo_full  input  1  local FIFO full flag.
- wrreq  output  1  one-cycle FIFO write strobe.
- fifo_data  output  DLEN  registered write data.
- busy  output  1  high while a handshake is open (grant != 0).
- pkt_cnt  output  CNT_W  count of packets written; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Clears grant=0, wrreq=0, fifo_data=0, busy=0, pkt_cnt=0.
  - Sets rr_ptr=0 (W has highest priority first) and state=IDLE.
  - Applies equally mid-handshake. The source then holds its request and is re-served after release.
- Source protocol, fixed:
  - Source presents data and raises its req bit on the same edge.
  - Data stays stable while req is high.
  - Source drops req the cycle after it sees its grant.
- State IDLE (grant=0, wrreq=0):
  - Trigger: (req != 0) && !fifo_full at a rising edge.
  - Selection: sel = first set req bit searching from index rr_ptr upward, modulo 5.
  - On the same edge: grant <= 1<<sel, fifo_data <= data of sel, wrreq <= 1, pkt_cnt <= pkt_cnt+1, state -> HOLD.
  - Latency: req high at edge t produces grant/wrreq visible after edge t+1 (one cycle).
- State HOLD:
  - wrreq <= 0 on the first edge, so wrreq is exactly one cycle wide.
  - Grant stays held while req[sel]=1.
  - When req[sel]=0: grant <= 0, rr_ptr <= (sel+1) mod 5, state -> IDLE.
  - No new selection is made in the same cycle as the release edge.
  - A request that stays high in HOLD is never written twice.
- Arbitration rules:
  - Requests arriving from other sources during HOLD wait; they are not lost.
  - With all five requesting continuously, service order from reset is W, S, E, N, L, W, ...
- fifo_full:
  - Sampled only in IDLE. When high, no grant is issued and requests wait.
  - Ignored in HOLD; the write has already been issued.
  - Writes are spaced at least 3 cycles apart, so a registered full flag is sufficient.
- Illegal or stale request:
  - A req bit that falls in IDLE before being granted is simply not served.
  - A req bit that falls during HOLD for a non-selected source has no effect.
- busy = (state==HOLD), registered.
- pkt_cnt increments by exactly one per wrreq pulse; 2^CNT_W-1 wraps to 0.

Test Plan:
- Single packet: after reset, req=00001 with data_w=0x0000_0105 held 2 cycles then dropped -> grant=00001 one cycle after req, wrreq=1 for exactly one cycle, fifo_data=0x0000_0105, grant returns to 0 one cycle after req falls, pkt_cnt=1.
- Round-robin: all five req held high, each source dropping its bit the cycle after its grant and re-raising 2 cycles later -> grant sequence 00001, 00010, 00100, 01000, 10000, 00001; ten wrreq pulses, pkt_cnt=10.
- Full back-pressure: fifo_full=1, req=01000 for 10 cycles -> grant=0, wrreq=0 throughout; drop fifo_full -> grant=01000 and wrreq next edge.
- Stuck request: req=00100 held high for 20 cycles -> exactly one wrreq, grant=00100 held the full time, pkt_cnt=1.
- Reset mid-handshake: reset_n low while grant=10000 -> grant, wrreq, busy, pkt_cnt immediately 0; after release with req=10000 still high -> regranted, pkt_cnt=1.
- Counter wrap with CNT_W=4: 17 packets -> pkt_cnt reads 15 after 15 packets, 0 after 16, 1 after 17.

Source files
------------

// File: rtl/noc_in_port.sv
// noc_in_port: receiving end of a router-to-router link.
// Five sources (L, N, E, S, W) raise one-hot requests. A round-robin arbiter
// picks one, returns a registered one-hot grant, and pushes the granted packet
// into the local input FIFO with a single-cycle write strobe. The grant is held
// until the selected source drops its request.
// Source index map (matches req/grant bit order): 0=W, 1=S, 2=E, 3=N, 4=L.
module noc_in_port #(
    parameter int DLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       req,
    input  logic [DLEN-1:0]  data_l,
    input  logic [DLEN-1:0]  data_n,
    input  logic [DLEN-1:0]  data_e,
    input  logic [DLEN-1:0]  data_s,
    input  logic [DLEN-1:0]  data_w,
    output logic [4:0]       grant,
    input  logic             fifo_full,
    output logic             wrreq,
    output logic [DLEN-1:0]  fifo_data,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;
    logic [2:0]        sel_q, sel_d;
    logic [4:0]        grant_q, grant_d;
    logic              wrreq_q, wrreq_d;
    logic [DLEN-1:0]   data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [2:0]        pick;
    logic              pick_vld;
    logic [3:0]        idx;
    logic [DLEN-1:0]   pick_data;

    // Round-robin search: first set request at or above rr_ptr, wrapping mod 5.
    always_comb begin
        pick     = 3'd0;
        pick_vld = 1'b0;
        idx      = 4'd0;
        for (int k = 0; k < 5; k++) begin
            idx = {1'b0, rr_ptr_q} + 4'(k);
            if (idx >= 4'd5) idx = idx - 4'd5;
            if (!pick_vld && req[idx[2:0]]) begin
                pick     = idx[2:0];
                pick_vld = 1'b1;
            end
        end
    end

    // Packet mux for the candidate source.
    always_comb begin
        pick_data = data_w;
        case (pick)
            3'd0:    pick_data = data_w;
            3'd1:    pick_data = data_s;
            3'd2:    pick_data = data_e;
            3'd3:    pick_data = data_n;
            3'd4:    pick_data = data_l;
            default: pick_data = data_w;
        endcase
    end

    // Next state: issue grant+write from IDLE, hold until the winner releases.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        grant_d  = grant_q;
        wrreq_d  = 1'b0;
        data_d   = data_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                // fifo_full only gates new grants; an issued write is never retracted.
                if (pick_vld && !fifo_full) begin
                    grant_d = 5'd1 << pick;
                    sel_d   = pick;
                    data_d  = pick_data;
                    wrreq_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Release only; the next selection waits for the following edge.
                if (!req[sel_q]) begin
                    grant_d  = 5'd0;
                    rr_ptr_d = (sel_q == 3'd4) ? 3'd0 : sel_q + 3'd1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 5'd0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= 3'd0;
            sel_q    <= 3'd0;
            grant_q  <= 5'd0;
            wrreq_q  <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            grant_q  <= grant_d;
            wrreq_q  <= wrreq_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant     = grant_q;
    assign wrreq     = wrreq_q;
    assign fifo_data = data_q;
    assign busy      = (state_q == HOLD);
    assign pkt_cnt   = cnt_q;

endmodule

// File: tb/tb_noc_in_port.sv
// Bench for noc_in_port: directed scenarios plus randomized traffic, every
// cycle compared against a transaction-level model of the link.
module tb_noc_in_port;
    localparam int DLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [4:0]       req = 5'd0;
    logic             fifo_full = 1'b0;
    logic [DLEN-1:0]  dsrc [5];
    logic [4:0]       grant;
    logic             wrreq;
    logic [DLEN-1:0]  fifo_data;
    logic             busy;
    logic [CNT_W-1:0] pkt_cnt;

    noc_in_port #(.DLEN(DLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .data_l(dsrc[4]), .data_n(dsrc[3]), .data_e(dsrc[2]),
        .data_s(dsrc[1]), .data_w(dsrc[0]),
        .grant(grant), .fifo_full(fifo_full), .wrreq(wrreq),
        .fifo_data(fifo_data), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    // Reference: who currently owns the link (-1 none), whose turn is next,
    // last packet written, write strobe this cycle, packets written.
    int          m_owner;
    int          m_turn;
    logic [31:0] m_data;
    logic        m_wr;
    int          m_cnt;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // Source-behaviour state for the automatic traffic modes.
    bit want [5];
    int cool [5];
    bit rand_mode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        assert (got === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] m_grant();
        return (m_owner < 0) ? 5'd0 : 5'(1 << m_owner);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_turn  = 0;
        m_data  = 32'd0;
        m_wr    = 1'b0;
        m_cnt   = 0;
    endtask

    // One clock edge worth of link behaviour, from the input values at the edge.
    task automatic model_edge();
        m_wr = 1'b0;
        if (m_owner < 0) begin
            if (!fifo_full) begin
                for (int k = 0; k < 5; k++) begin
                    int s;
                    s = (m_turn + k) % 5;
                    if (req[s]) begin
                        m_owner = s;
                        m_data  = dsrc[s];
                        m_wr    = 1'b1;
                        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
                        break;
                    end
                end
            end
        end else if (!req[m_owner]) begin
            m_turn  = (m_owner + 1) % 5;
            m_owner = -1;
        end
    endtask

    task automatic check_all();
        chk("grant",     64'(grant),     64'(m_grant()));
        chk("wrreq",     64'(wrreq),     64'(m_wr));
        chk("busy",      64'(busy),      64'(m_owner >= 0));
        chk("fifo_data", 64'(fifo_data), 64'(m_data));
        chk("pkt_cnt",   64'(pkt_cnt),   64'(m_cnt));
    endtask

    // Advance one cycle; returns at the falling edge after checking outputs.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset pulse applied between edges; requests are left as-is.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        reset_n = 1'b1;
    endtask

    // Sources follow the link protocol: drop req after seeing grant, re-raise later.
    task automatic sources();
        for (int s = 0; s < 5; s++) begin
            if (req[s]) begin
                if (m_owner == s) begin
                    req[s]  = 1'b0;
                    cool[s] = rand_mode ? int'($urandom_range(0, 4)) : 2;
                end else if (rand_mode && $urandom_range(0, 29) == 0) begin
                    req[s] = 1'b0;
                end
            end else if (want[s]) begin
                if (cool[s] > 0) cool[s] = cool[s] - 1;
                else if (!rand_mode || $urandom_range(0, 2) == 0) begin
                    dsrc[s] = $urandom;
                    req[s]  = 1'b1;
                end
            end
        end
    endtask

    initial begin
        logic [4:0] order [$];
        int wrs;
        for (int s = 0; s < 5; s++) begin
            dsrc[s] = 32'd0;
            want[s] = 1'b0;
            cool[s] = 0;
        end
        model_reset();
        @(negedge clk);
        check_all();
        reset_n = 1'b1;

        // Single packet from W.
        dsrc[0] = 32'h0000_0105;
        req     = 5'b00001;
        tick();
        chk("single_grant", 64'(grant), 64'h01);
        chk("single_wr",    64'(wrreq), 64'h1);
        chk("single_data",  64'(fifo_data), 64'h105);
        tick();
        chk("single_wr_width", 64'(wrreq), 64'h0);
        chk("single_hold",     64'(grant), 64'h01);
        req = 5'b00000;
        tick();
        chk("single_release", 64'(grant), 64'h00);
        chk("single_cnt",     64'(pkt_cnt), 64'd1);
        tick();

        // Round-robin with all five sources active.
        do_reset();
        for (int s = 0; s < 5; s++) begin
            want[s] = 1'b1;
            cool[s] = 0;
        end
        sources();
        wrs = 0;
        for (int c = 0; c < 200 && wrs < 10; c++) begin
            tick();
            if (wrreq) begin
                order.push_back(grant);
                wrs = wrs + 1;
            end
            sources();
        end
        chk("rr_pulses", 64'(wrs), 64'd10);
        for (int i = 0; i < 10 && i < order.size(); i++)
            chk("rr_order", 64'(order[i]), 64'(5'd1 << (i % 5)));
        chk("rr_cnt", 64'(pkt_cnt), 64'd10);
        for (int s = 0; s < 5; s++) want[s] = 1'b0;
        req = 5'd0;
        tick();
        tick();

        // Full back-pressure on N.
        do_reset();
        fifo_full = 1'b1;
        dsrc[3]   = 32'hCAFE_0003;
        req       = 5'b01000;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("full_nogrant", 64'(grant), 64'h0);
            chk("full_nowr",    64'(wrreq), 64'h0);
        end
        fifo_full = 1'b0;
        tick();
        chk("full_grant", 64'(grant), 64'h08);
        chk("full_wr",    64'(wrreq), 64'h1);
        chk("full_data",  64'(fifo_data), 64'hCAFE_0003);
        req = 5'd0;
        tick();

        // Stuck request on E.
        do_reset();
        dsrc[2] = $urandom;
        req     = 5'b00100;
        wrs     = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (wrreq) wrs = wrs + 1;
        end
        chk("stuck_wrs",   64'(wrs), 64'd1);
        chk("stuck_grant", 64'(grant), 64'h04);
        chk("stuck_cnt",   64'(pkt_cnt), 64'd1);
        req = 5'd0;
        tick();

        // Reset in the middle of an L handshake.
        do_reset();
        dsrc[4] = 32'h1234_5678;
        req     = 5'b10000;
        tick();
        chk("mid_grant", 64'(grant), 64'h10);
        do_reset();
        chk("mid_rst_grant", 64'(grant), 64'h0);
        chk("mid_rst_cnt",   64'(pkt_cnt), 64'd0);
        tick();
        chk("mid_regrant", 64'(grant), 64'h10);
        chk("mid_cnt",     64'(pkt_cnt), 64'd1);
        req = 5'd0;
        tick();

        // Counter wrap (4-bit counter).
        do_reset();
        for (int p = 1; p <= 17; p++) begin
            dsrc[0] = $urandom;
            req     = 5'b00001;
            tick();
            req = 5'b00000;
            tick();
            if (p == 15) chk("wrap_15", 64'(pkt_cnt), 64'd15);
            if (p == 16) chk("wrap_16", 64'(pkt_cnt), 64'd0);
            if (p == 17) chk("wrap_17", 64'(pkt_cnt), 64'd1);
        end

        // Randomized traffic with back-pressure and withdrawn requests.
        do_reset();
        rand_mode = 1'b1;
        for (int s = 0; s < 5; s++) begin
            want[s] = ($urandom_range(0, 3) != 0);
            cool[s] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) fifo_full = ~fifo_full;
            if ($urandom_range(0, 99) == 0) want[$urandom_range(0, 4)] ^= 1'b1;
            sources();
            tick();
        end
        fifo_full = 1'b0;
        req = 5'd0;
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
